// File: rtl/zif_eprom_reader.sv
// zif_eprom_reader
// -----------------------------------------------------------------------------
// Command-driven parallel EPROM read sequencer for the ZIF socket. It takes one
// command per bus write strobe. It drives the device address, CE# and OE#, and
// waits a programmable access time in osc cycles. It then samples the 8-bit
// device data and queues it for the bus read section.
//
// Build option:
//   ZIF_EPROM_READER_BURST_EN  defined   -> BURST opcode implemented and the
//                                           output queue is FIFO_DEPTH deep
//                              undefined -> BURST is a NOP and the queue is a
//                                           single holding register
//
// Ports:
//   osc          in   24 MHz clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   cmd_valid    in   command present
//   cmd_op[2:0]  in   0 NOP, 1 ADDR_LO, 2 ADDR_HI, 3 TACC, 4 READ1, 5 BURST
//   cmd_arg[7:0] in   command argument
//   cmd_ready    out  high only in IDLE; accept on cmd_valid && cmd_ready
//   rd_data[7:0] out  head of the output queue
//   rd_valid     out  queue non-empty
//   rd_pop       in   discard the head (ignored while rd_valid is low)
//   busy         out  sequencer not idle
//   zif_addr     out  device address
//   zif_ce_n     out  chip enable, active low
//   zif_oe_n     out  output enable, active low
//   zif_data_in  in   device data bus
// -----------------------------------------------------------------------------
module zif_eprom_reader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  TACC_RESET = 8'd6
) (
    input  logic        osc,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_arg,
    output logic        cmd_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_pop,
    output logic        busy,
    output logic [15:0] zif_addr,
    output logic        zif_ce_n,
    output logic        zif_oe_n,
    input  logic [7:0]  zif_data_in
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FULLWAIT = 3'd1,
        ST_SETUP    = 3'd2,
        ST_ACCESS   = 3'd3,
        ST_RECOVER  = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADDR_LO = 3'd1;
    localparam logic [2:0] OP_ADDR_HI = 3'd2;
    localparam logic [2:0] OP_TACC    = 3'd3;
    localparam logic [2:0] OP_READ1   = 3'd4;
`ifdef ZIF_EPROM_READER_BURST_EN
    localparam logic [2:0] OP_BURST   = 3'd5;
    localparam int unsigned QDEPTH    = FIFO_DEPTH;
`else
    // A single holding register; FIFO_DEPTH has no effect in this build.
    localparam int unsigned QDEPTH    = (FIFO_DEPTH != 0) ? 1 : 1;
`endif
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    state_t        state_q, state_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    tacc_q, tacc_d;
    logic [8:0]    remaining_q, remaining_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [15:0]   zif_addr_q, zif_addr_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          busy_q, busy_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    head_q, head_d;
    logic          rd_valid_q, rd_valid_d;
    logic          push_s;
    logic          pop_s;
    logic          full_s;

    assign full_s = (count_q == CW'(QDEPTH));
    assign pop_s  = rd_pop && rd_valid_q;

    // Sequencer next state, address/timing registers and pin values.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        tacc_d      = tacc_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        push_s      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    case (cmd_op)
                        OP_ADDR_LO: addr_d[7:0]  = cmd_arg;
                        OP_ADDR_HI: addr_d[15:8] = cmd_arg;
                        // A zero access time would skip ACCESS; clamp to 1.
                        OP_TACC:    tacc_d = (cmd_arg == 8'd0) ? 8'd1 : cmd_arg;
                        OP_READ1: begin
                            remaining_d = 9'd1;
                            state_d     = full_s ? ST_FULLWAIT : ST_SETUP;
                        end
`ifdef ZIF_EPROM_READER_BURST_EN
                        OP_BURST: begin
                            remaining_d = {1'b0, cmd_arg} + 9'd1;
                            state_d     = full_s ? ST_FULLWAIT : ST_SETUP;
                        end
`endif
                        default:    state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FULLWAIT: state_d = full_s ? ST_FULLWAIT : ST_SETUP;
            ST_SETUP: begin
                cnt_d   = tacc_q;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt_q <= 8'd1) begin
                    // Last access cycle: this edge samples the device.
                    push_s      = 1'b1;
                    addr_d      = addr_q + 16'd1;
                    remaining_d = remaining_q - 9'd1;
                    state_d     = ST_RECOVER;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RECOVER: begin
                if (remaining_q == 9'd0) begin
                    state_d = ST_IDLE;
                end else if (full_s) begin
                    state_d = ST_FULLWAIT;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pins are registered from the next state so they line up with it.
        if (state_d == ST_SETUP) begin
            zif_addr_d = addr_q;
        end else begin
            zif_addr_d = zif_addr_q;
        end
        ce_n_d      = !((state_d == ST_SETUP) || (state_d == ST_ACCESS));
        oe_n_d      = (state_d != ST_ACCESS);
        busy_d      = (state_d != ST_IDLE);
        cmd_ready_d = (state_d == ST_IDLE);
    end

`ifdef ZIF_EPROM_READER_BURST_EN
    localparam int unsigned PW = $clog2(QDEPTH);

    logic [7:0]    mem_q [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    // Queue pointers, occupancy and the registered head byte.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d  = count_q + CW'(push_s) - CW'(pop_s);
        if (pop_s) begin
            if (count_q > CW'(1)) begin
                head_d = mem_q[rd_ptr_q + PW'(1)];
            end else if (push_s) begin
                head_d = zif_data_in;
            end else begin
                head_d = head_q;
            end
        end else if ((count_q == CW'(0)) && push_s) begin
            head_d = zif_data_in;
        end else begin
            head_d = head_q;
        end
        rd_valid_d = (count_d != CW'(0));
    end

    // Queue storage; contents need no reset because occupancy gates them.
    always_ff @(posedge osc) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= zif_data_in;
        end
    end

    // Queue pointer registers.
    always_ff @(posedge osc) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
`else
    // Single holding register: a push only happens when it is empty.
    always_comb begin
        if (push_s) begin
            count_d = CW'(1);
            head_d  = zif_data_in;
        end else if (pop_s) begin
            count_d = CW'(0);
            head_d  = head_q;
        end else begin
            count_d = count_q;
            head_d  = head_q;
        end
        rd_valid_d = (count_d != CW'(0));
    end
`endif

    // State, datapath and output registers.
    always_ff @(posedge osc) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= 16'h0000;
            tacc_q      <= TACC_RESET;
            remaining_q <= 9'd0;
            cnt_q       <= 8'd0;
            zif_addr_q  <= 16'h0000;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            count_q     <= '0;
            head_q      <= 8'h00;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tacc_q      <= tacc_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            zif_addr_q  <= zif_addr_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
            count_q     <= count_d;
            head_q      <= head_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rd_data   = head_q;
    assign rd_valid  = rd_valid_q;
    assign busy      = busy_q;
    assign zif_addr  = zif_addr_q;
    assign zif_ce_n  = ce_n_q;
    assign zif_oe_n  = oe_n_q;

endmodule

// File: tb/tb_zif_eprom_reader.sv
// Testbench for zif_eprom_reader: directed scenarios plus randomized command
// traffic. It is checked against a transaction-level model that tracks the
// address, the access time, and the expected address/byte sequences.
`timescale 1ns/1ps
module tb_zif_eprom_reader;

`ifdef ZIF_EPROM_READER_BURST_EN
    localparam int         QD       = 4;
    localparam logic [2:0] RD_OP    = 3'd5;
    localparam logic       BUSY_POP = 1'b1;
`else
    localparam int         QD       = 1;
    localparam logic [2:0] RD_OP    = 3'd4;
    localparam logic       BUSY_POP = 1'b0;
`endif
    localparam logic [7:0] TACC_RST = 8'd6;

    logic        osc = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [7:0]  cmd_arg = 8'd0;
    logic        cmd_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_pop = 1'b0;
    logic        busy;
    logic [15:0] zif_addr;
    logic        zif_ce_n;
    logic        zif_oe_n;
    logic [7:0]  zif_data_in;

    zif_eprom_reader #(.FIFO_DEPTH(4), .TACC_RESET(TACC_RST)) dut (
        .osc(osc), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_arg(cmd_arg), .cmd_ready(cmd_ready), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_pop(rd_pop), .busy(busy),
        .zif_addr(zif_addr), .zif_ce_n(zif_ce_n), .zif_oe_n(zif_oe_n),
        .zif_data_in(zif_data_in)
    );

    always #20 osc = ~osc;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state.
    logic [15:0] addr_m = 16'h0000;
    int          tacc_m = 6;
    logic [15:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    logic [7:0]  salt = 8'h5A;
    logic        force_en = 1'b0;
    logic [7:0]  force_val = 8'h00;

    function automatic logic [7:0] image(input logic [15:0] a);
        return (a[7:0] * 8'd13) ^ a[15:8] ^ salt;
    endfunction

    // Device model: the correct byte is only on the bus in the final
    // access cycle, so early or late sampling returns a wrong byte.
    int oe_cyc = 0;
    always @(posedge osc) oe_cyc <= zif_oe_n ? 0 : oe_cyc + 1;
    assign zif_data_in = force_en ? force_val :
        ((!zif_oe_n && (oe_cyc == tacc_m - 1)) ? image(zif_addr) : ~image(zif_addr));

    function automatic void enqueue(input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(addr_m);
            exp_data_q.push_back(force_en ? force_val : image(addr_m));
            addr_m = addr_m + 16'd1;
        end
    endfunction

    function automatic void model_accept(input logic [2:0] op, input logic [7:0] arg);
        case (op)
            3'd1: addr_m[7:0]  = arg;
            3'd2: addr_m[15:8] = arg;
            3'd3: tacc_m = (arg == 8'd0) ? 1 : int'(arg);
            3'd4: enqueue(1);
`ifdef ZIF_EPROM_READER_BURST_EN
            3'd5: enqueue(int'(arg) + 1);
`endif
            default: ;
        endcase
    endfunction

    // Bus monitor: SETUP addresses, OE# width and popped bytes.
    int oe_run = 0;
    int setup_cnt = 0;
    always @(negedge osc) begin
        if (rst) begin
            oe_run = 0;
        end else begin
            if (!zif_ce_n && zif_oe_n) begin
                setup_cnt++;
                check_val("setup_pending", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) check_val("setup_addr", 32'(zif_addr), 32'(exp_addr_q.pop_front()));
            end
            if (!zif_oe_n) begin
                oe_run++;
                check_val("ce_during_oe", 32'(zif_ce_n), 32'd0);
            end else if (oe_run != 0) begin
                check_val("oe_width", 32'(oe_run), 32'(tacc_m));
                oe_run = 0;
            end
            if (rd_pop && rd_valid) begin
                check_val("pop_pending", 32'(exp_data_q.size() != 0), 32'd1);
                if (exp_data_q.size() != 0) check_val("pop_data", 32'(rd_data), 32'(exp_data_q.pop_front()));
            end
        end
    end

    task automatic send_cmd(input logic [2:0] op, input logic [7:0] arg);
        int w = 0;
        while (!cmd_ready && w < 3000) begin
            @(posedge osc); #1;
            w++;
        end
        check_val("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        @(posedge osc); #1;
        cmd_valid = 1'b0;
        model_accept(op, arg);
    endtask

    task automatic wait_idle(input int pop_pct);
        int n = 0;
        while (busy && n < 3000) begin
            rd_pop = ($urandom_range(99) < pop_pct);
            @(posedge osc); #1;
            n++;
        end
        rd_pop = 1'b0;
        check_val("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (rd_valid && n < 300) begin
            rd_pop = 1'b1;
            @(posedge osc); #1;
            n++;
        end
        rd_pop = 1'b0;
        check_val("drain_empty", 32'(rd_valid), 32'd0);
        check_val("model_empty", 32'(exp_data_q.size()), 32'd0);
    endtask

    task automatic pop_once();
        rd_pop = 1'b1;
        @(posedge osc); #1;
        rd_pop = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int bfall;
        int base;
        int w;
        logic [2:0] op;
        logic [7:0] arg;

        salt = 8'($urandom_range(255));
        tacc_m = int'(TACC_RST);
        repeat (3) @(posedge osc);
        #1;
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_val("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_val("rst_rd_data", 32'(rd_data), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_zif_addr", 32'(zif_addr), 32'd0);
        check_val("rst_ce_n", 32'(zif_ce_n), 32'd1);
        check_val("rst_oe_n", 32'(zif_oe_n), 32'd1);
        rst = 1'b0;

        // Single read at 0x1234, tacc 3, constant 0xA5 on the bus.
        force_en = 1'b1; force_val = 8'hA5;
        send_cmd(3'd1, 8'h34);
        send_cmd(3'd2, 8'h12);
        send_cmd(3'd3, 8'd3);
        send_cmd(3'd4, 8'd0);
        check_val("t1_setup_addr", 32'(zif_addr), 32'h1234);
        check_val("t1_setup_ce", 32'(zif_ce_n), 32'd0);
        check_val("t1_setup_oe", 32'(zif_oe_n), 32'd1);
        check_val("t1_cmd_ready", 32'(cmd_ready), 32'd0);
        lat = 0; bfall = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge osc); #1;
            if (rd_valid && lat == 0) lat = k;
            if (!busy && bfall == 0) bfall = k;
            if (lat != 0 && bfall != 0) break;
        end
        check_val("t1_latency", 32'(lat), 32'd4);
        check_val("t1_busy_fall", 32'(bfall), 32'd5);
        check_val("t1_data", 32'(rd_data), 32'hA5);
        drain();
        force_en = 1'b0;

        // tacc 0 is clamped to 1: byte two edges after accept, addr 0x1235.
        send_cmd(3'd3, 8'd0);
        send_cmd(3'd4, 8'd0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge osc); #1;
            if (rd_valid) begin lat = k; break; end
        end
        check_val("t0_latency", 32'(lat), 32'd2);
        wait_idle(0);
        drain();

        // Address wrap 0xFFFF -> 0x0000, then the next read starts at 0x0001.
        send_cmd(3'd3, 8'($urandom_range(1, 3)));
        send_cmd(3'd1, 8'hFF);
        send_cmd(3'd2, 8'hFF);
`ifdef ZIF_EPROM_READER_BURST_EN
        send_cmd(3'd5, 8'd1);
`else
        send_cmd(3'd5, 8'd1);
        for (int k = 0; k < 4; k++) begin
            check_val("burst_nop_busy", 32'(busy), 32'd0);
            @(posedge osc); #1;
        end
        send_cmd(3'd4, 8'd0);
        wait_idle(0);
        drain();
        send_cmd(3'd4, 8'd0);
`endif
        wait_idle(50);
        drain();
        send_cmd(3'd4, 8'd0);
        wait_idle(50);
        drain();

        // Backpressure: the queue fills, then the engine parks in FULLWAIT.
        send_cmd(3'd3, 8'd2);
        base = setup_cnt;
`ifdef ZIF_EPROM_READER_BURST_EN
        send_cmd(3'd5, 8'd9);
`else
        send_cmd(3'd4, 8'd0);
        wait_idle(0);
        send_cmd(3'd4, 8'd0);
`endif
        repeat (100) @(posedge osc);
        #1;
        check_val("bp_setups", 32'(setup_cnt - base), 32'(QD));
        check_val("bp_busy", 32'(busy), 32'd1);
        check_val("bp_ce_n", 32'(zif_ce_n), 32'd1);
        check_val("bp_oe_n", 32'(zif_oe_n), 32'd1);
        check_val("bp_rd_valid", 32'(rd_valid), 32'd1);
        pop_once();
        repeat (50) @(posedge osc);
        #1;
        check_val("bp_pop_setups", 32'(setup_cnt - base), 32'(QD + 1));
        check_val("bp_pop_busy", 32'(busy), 32'(BUSY_POP));
        check_val("bp_pop_ce_n", 32'(zif_ce_n), 32'd1);
        wait_idle(100);
        drain();

        // Reset in the middle of an access.
        send_cmd(3'd3, 8'd5);
        send_cmd(RD_OP, 8'd3);
        w = 0;
        while (zif_oe_n && w < 100) begin
            @(posedge osc); #1;
            w++;
        end
        check_val("rst_reach_access", 32'(zif_oe_n), 32'd0);
        rst = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
        addr_m = 16'h0000;
        tacc_m = int'(TACC_RST);
        @(posedge osc); #1;
        check_val("mid_rst_ce_n", 32'(zif_ce_n), 32'd1);
        check_val("mid_rst_oe_n", 32'(zif_oe_n), 32'd1);
        check_val("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        check_val("mid_rst_zif_addr", 32'(zif_addr), 32'd0);
        check_val("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;
        send_cmd(3'd4, 8'd0);
        wait_idle(0);
        drain();

        // Randomized command traffic with random pops.
        for (int it = 0; it < 60; it++) begin
            op = 3'($urandom_range(7));
            if (op == 3'd3) arg = 8'($urandom_range(4));
            else if (op == 3'd5) arg = 8'($urandom_range(6));
            else arg = 8'($urandom_range(255));
            send_cmd(op, arg);
            wait_idle(60);
            if ($urandom_range(3) == 0) drain();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
